// File: rtl/bcd_run_pkg.sv
// bcd_run_pkg: shared state encoding, digit geometry and BCD increment helper for the run counter
package bcd_run_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W = 4;
  // Returns {carry_out, digit}; a set carry_in advances the digit, wrapping 9 to 0
  function automatic logic [DIGIT_W:0] bcd_inc(input logic [DIGIT_W-1:0] d, input logic cin);
    return !cin ? {1'b0, d} : (d >= 4'd9) ? {1'b1, 4'd0} : {1'b0, d + 4'd1};
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: two-flop synchronizer, stability counter and one-cycle press pulse for a raw button
module button_debounce #(
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level, level_q, differ, done;
  assign differ = sync[1] ^ level;
  assign done = differ && cnt == CW'(DEB_CYCLES - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      level_q <= 1'b0;
      press <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      cnt <= (differ && !done) ? cnt + 1'b1 : '0;
      level <= done ? ~level : level;
      level_q <= level;
      press <= level & ~level_q;
    end
  end
endmodule

// File: rtl/bcd_run_counter.sv
// bcd_run_counter: six-digit BCD run/pause counter with debounced start/stop and clear buttons
module bcd_run_counter
  import bcd_run_pkg::*;
#(
  parameter int TICK_DIV = 500_000,
  parameter int DEB_CYCLES = 500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start_stop,
  input  logic clear,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic running,
  output logic update,
  output logic rollover
);
  localparam int PW = $clog2(TICK_DIV);
  state_t state, state_nx;
  logic [PW-1:0] presc;
  logic [NUM_DIGITS*DIGIT_W-1:0] cnt, cnt_inc;
  logic ss_press, clr_press, tick, wrap;
  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_ss (
    .clk(clk), .reset(reset), .raw(start_stop), .press(ss_press)
  );
  button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
    .clk(clk), .reset(reset), .raw(clear), .press(clr_press)
  );
  assign tick = state == RUN && presc == PW'(TICK_DIV - 1);
  always_comb begin
    logic c;
    c = 1'b1;
    cnt_inc = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      {c, cnt_inc[i*DIGIT_W +: DIGIT_W]} = bcd_inc(cnt[i*DIGIT_W +: DIGIT_W], c);
    wrap = c;
  end
  // Clear outranks start/stop when both presses land on the same cycle
  always_comb begin
    state_nx = clr_press ? IDLE : !ss_press ? state : (state == RUN) ? PAUSE : RUN;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
      cnt <= '0;
      update <= 1'b0;
      rollover <= 1'b0;
    end else begin
      update <= 1'b0;
      rollover <= 1'b0;
      if (clr_press) begin
        cnt <= '0;
        presc <= '0;
        update <= |cnt;
      end else if (tick) begin
        cnt <= cnt_inc;
        presc <= '0;
        update <= 1'b1;
        rollover <= wrap;
      end else if (state == RUN) begin
        presc <= presc + 1'b1;
      end
    end
  end
  assign digits = cnt;
  assign running = state == RUN;
endmodule

// File: tb/tb_bcd_run_counter.sv
// tb_bcd_run_counter: directed scenarios checked every cycle against a decimal-arithmetic model
module tb_bcd_run_counter;
  localparam int TD = 4;
  localparam int DB = 3;
  logic clk = 0, reset = 1, start_stop = 0, clear = 0;
  logic [23:0] digits;
  logic running, update, rollover;
  int tests = 0, fails = 0;
  int m_state, m_val, m_ph;
  bit m_upd, m_roll;
  bit d1[2], d2[2], r1[2], r2[2], lvl[2];
  bit win[2][DB];
  bit ld_req = 0;
  int ld_int = 0;
  logic [23:0] ld_val = '0;

  bcd_run_counter #(.TICK_DIV(TD), .DEB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
    .digits(digits), .running(running), .update(update), .rollover(rollover)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Model: a button event fires two edges after the synchronized input has disagreed
  // with the debounced level for DB straight cycles; the count is a plain integer.
  always @(posedge clk or posedge reset) begin
    bit raw[2], ev[2], s, all;
    if (reset) begin
      m_state = 0; m_val = 0; m_ph = 0; m_upd = 0; m_roll = 0;
      for (int b = 0; b < 2; b++) begin
        d1[b] = 0; d2[b] = 0; r1[b] = 0; r2[b] = 0; lvl[b] = 0;
        for (int i = 0; i < DB; i++) win[b][i] = 0;
      end
    end else begin
      raw[0] = start_stop;
      raw[1] = clear;
      for (int b = 0; b < 2; b++) begin
        s = r2[b]; r2[b] = r1[b]; r1[b] = raw[b];
        for (int i = DB - 1; i > 0; i--) win[b][i] = win[b][i-1];
        win[b][0] = s;
        all = 1;
        for (int i = 0; i < DB; i++) if (win[b][i] == lvl[b]) all = 0;
        ev[b] = d2[b]; d2[b] = d1[b]; d1[b] = all && !lvl[b];
        if (all) lvl[b] = !lvl[b];
      end
      m_upd = 0; m_roll = 0;
      if (ld_req) m_val = ld_int;
      if (ev[1]) begin
        m_upd = (m_val != 0); m_val = 0; m_ph = 0; m_state = 0;
      end else begin
        if (m_state == 1) begin
          if (m_ph == TD - 1) begin
            m_ph = 0; m_val = (m_val + 1) % 1000000; m_upd = 1; m_roll = (m_val == 0);
          end else m_ph++;
        end
        if (ev[0]) m_state = (m_state == 1) ? 2 : 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [23:0] exp_d;
    bit bad;
    if (!reset && !ld_req) begin
      exp_d = to_bcd(m_val);
      bad = 0;
      for (int i = 0; i < 6; i++) if (digits[i*4 +: 4] > 4'd9) bad = 1;
      tests += 5;
      if (digits !== exp_d) begin fails++; $display("FAIL model_digits t=%0t got %h exp %h", $time, digits, exp_d); end
      if (running !== (m_state == 1)) begin fails++; $display("FAIL model_running t=%0t got %b exp %b", $time, running, m_state == 1); end
      if (update !== m_upd) begin fails++; $display("FAIL model_update t=%0t got %b exp %b", $time, update, m_upd); end
      if (rollover !== m_roll) begin fails++; $display("FAIL model_rollover t=%0t got %b exp %b", $time, rollover, m_roll); end
      if (bad) begin fails++; $display("FAIL nibble_range t=%0t got %h exp all nibbles <= 9", $time, digits); end
    end
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin fails++; $display("FAIL %s got %0h exp %0h", nm, a, e); end
  endtask

  task automatic wait_run(input bit want);
    int k = 0;
    while (running !== want && k < 30) begin @(negedge clk); k++; end
    chk("wait_running", 32'(running), 32'(want));
  endtask

  task automatic wait_upd();
    int k = 0;
    while (update !== 1'b1 && k < 30) begin @(negedge clk); k++; end
    chk("wait_update", 32'(update), 32'd1);
  endtask

  task automatic press_ss(input bit want);
    repeat (8) @(negedge clk);
    start_stop = 1;
    repeat (6) @(negedge clk);
    start_stop = 0;
    wait_run(want);
  endtask

  task automatic load(input logic [23:0] b, input int v);
    @(posedge clk); #1;
    ld_val = b; ld_int = v; ld_req = 1;
    force dut.cnt = ld_val;
    @(posedge clk); #1;
    release dut.cnt;
    ld_req = 0;
    @(negedge clk);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (20) @(negedge clk);
    chk("idle_digits", 32'(digits), 32'h0);
    chk("idle_running", 32'(running), 32'h0);
    start_stop = 1;
    k = 0;
    while (running !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("press_latency", k, 7);
    repeat (4) @(negedge clk);
    chk("first_tick", 32'(digits), 32'h000001);
    chk("first_update", 32'(update), 32'h1);
    start_stop = 0;
    repeat (4) @(negedge clk);
    chk("second_tick", 32'(digits), 32'h000002);
    repeat (8) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      start_stop = 1;
      repeat (2) @(negedge clk);
      start_stop = 0;
      repeat (4) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("bounce_still_running", 32'(running), 32'h1);
    press_ss(0);
    repeat (40) @(negedge clk);
    press_ss(1);
    repeat (12) @(negedge clk);
    press_ss(0);
    load(24'h000009, 9);
    press_ss(1);
    wait_upd();
    chk("carry_9", 32'(digits), 32'h000010);
    press_ss(0);
    load(24'h000099, 99);
    press_ss(1);
    wait_upd();
    chk("carry_99", 32'(digits), 32'h000100);
    press_ss(0);
    load(24'h999999, 999999);
    press_ss(1);
    wait_upd();
    chk("wrap_digits", 32'(digits), 32'h000000);
    chk("wrap_rollover", 32'(rollover), 32'h1);
    chk("wrap_running", 32'(running), 32'h1);
    @(negedge clk);
    chk("rollover_one_cycle", 32'(rollover), 32'h0);
    wait_upd();
    chk("after_wrap", 32'(digits), 32'h000001);
    repeat (8) @(negedge clk);
    start_stop = 1;
    clear = 1;
    repeat (6) @(negedge clk);
    start_stop = 0;
    clear = 0;
    wait_run(0);
    chk("clear_digits", 32'(digits), 32'h0);
    repeat (10) @(negedge clk);
    chk("clear_wins", 32'(running), 32'h0);
    press_ss(1);
    repeat (6) @(negedge clk);
    #2 reset = 1;
    #1;
    chk("reset_digits", 32'(digits), 32'h0);
    chk("reset_running", 32'(running), 32'h0);
    chk("reset_update", 32'(update), 32'h0);
    chk("reset_rollover", 32'(rollover), 32'h0);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (10) @(negedge clk);
    chk("post_reset_idle", 32'(running), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish exp finish before 100000");
    $fatal(1, "timeout");
  end
endmodule
